// File: rtl/auth_attempt_controller.sv
// auth_attempt_controller
//  Downstream stage of the 8-bit auth comparator. Accepts one verdict per attempt
//  while idle, grants access for GRANT_CYCLES on a pass, and counts consecutive
//  failures. The MAX_FAILS-th consecutive failure starts a LOCK_CYCLES lockout.
//  Optional feature macro: AUDIT_COUNT_EN adds a 16-bit saturating total_fails
//  counter that only rst clears.
module auth_attempt_controller #(
   parameter int unsigned MAX_FAILS    = 3,
   parameter int unsigned LOCK_CYCLES  = 16,
   parameter int unsigned GRANT_CYCLES = 4,
   localparam int unsigned FAIL_W      = $clog2(MAX_FAILS + 1),
   localparam int unsigned TMR_MAX     = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES,
   localparam int unsigned TMR_W       = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              attempt_valid,
   input  logic              matched,
   input  logic              unmatched,
   output logic              attempt_ready,
   output logic              access_granted,
   output logic              locked_out,
   output logic [FAIL_W-1:0] fail_count
`ifdef AUDIT_COUNT_EN
   ,
   output logic [15:0]       total_fails
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [FAIL_W-1:0]  fail_count_q, fail_count_d;
   logic [TMR_W-1:0]   timer_q, timer_d;

   logic               accept_s;
   logic               pass_s;
   logic [FAIL_W-1:0]  fail_inc_s;

   // Handshake and verdict decode; only a clean matched=1/unmatched=0 is a pass.
   assign accept_s   = attempt_valid & attempt_ready;
   assign pass_s     = matched & ~unmatched;
   // fail_count stays below MAX_FAILS while idle, so the increment never overflows.
   assign fail_inc_s = fail_count_q + FAIL_W'(1);

   // Outputs are pure decodes of the state register.
   assign attempt_ready  = (state_q == ST_IDLE);
   assign access_granted = (state_q == ST_GRANT);
   assign locked_out     = (state_q == ST_LOCKED);
   assign fail_count     = fail_count_q;

   // State, failure counter and timer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         fail_count_q <= {FAIL_W{1'b0}};
         timer_q      <= {TMR_W{1'b0}};
      end else begin
         state_q      <= state_d;
         fail_count_q <= fail_count_d;
         timer_q      <= timer_d;
      end
   end

   // Next-state logic: attempt evaluation in IDLE, timed hold in GRANT/LOCKED.
   always_comb begin
      state_d      = state_q;
      fail_count_d = fail_count_q;
      timer_d      = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (pass_s) begin
                  state_d      = ST_GRANT;
                  fail_count_d = {FAIL_W{1'b0}};
                  timer_d      = TMR_W'(GRANT_CYCLES - 1);
               end else if (fail_inc_s == FAIL_W'(MAX_FAILS)) begin
                  state_d      = ST_LOCKED;
                  fail_count_d = FAIL_W'(MAX_FAILS);
                  timer_d      = TMR_W'(LOCK_CYCLES - 1);
               end else begin
                  fail_count_d = fail_inc_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (timer_q == {TMR_W{1'b0}}) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_LOCKED: begin
            if (timer_q == {TMR_W{1'b0}}) begin
               state_d      = ST_IDLE;
               fail_count_d = {FAIL_W{1'b0}};
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            // Unreachable encoding: recover to a safe idle state.
            state_d      = ST_IDLE;
            fail_count_d = {FAIL_W{1'b0}};
            timer_d      = {TMR_W{1'b0}};
         end
      endcase
   end

`ifdef AUDIT_COUNT_EN
   logic [15:0] total_fails_q, total_fails_d;

   assign total_fails = total_fails_q;

   // Lifetime failure tally: counts every accepted fail and saturates at all-ones.
   always_comb begin
      total_fails_d = total_fails_q;
      if (accept_s && !pass_s && (total_fails_q != 16'hFFFF)) begin
         total_fails_d = total_fails_q + 16'd1;
      end else begin
         total_fails_d = total_fails_q;
      end
   end

   // Audit counter register; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         total_fails_q <= 16'd0;
      end else begin
         total_fails_q <= total_fails_d;
      end
   end
`endif

endmodule

// File: tb/tb_auth_attempt_controller.sv
// Directed testbench for auth_attempt_controller (MAX_FAILS=3, LOCK_CYCLES=16,
// GRANT_CYCLES=4). Observed status is packed as {ready, granted, locked, fail_count}.
module tb_auth_attempt_controller;

   logic       clk;
   logic       rst;
   logic       attempt_valid;
   logic       matched;
   logic       unmatched;
   logic       attempt_ready;
   logic       access_granted;
   logic       locked_out;
   logic [1:0] fail_count;
`ifdef AUDIT_COUNT_EN
   logic [15:0] total_fails;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   auth_attempt_controller #(
      .MAX_FAILS   (3),
      .LOCK_CYCLES (16),
      .GRANT_CYCLES(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .attempt_valid (attempt_valid),
      .matched       (matched),
      .unmatched     (unmatched),
      .attempt_ready (attempt_ready),
      .access_granted(access_granted),
      .locked_out    (locked_out),
      .fail_count    (fail_count)
`ifdef AUDIT_COUNT_EN
      ,
      .total_fails   (total_fails)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] status();
      return {attempt_ready, access_granted, locked_out, fail_count};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic m, input logic u);
      attempt_valid = v;
      matched       = m;
      unmatched     = u;
   endtask

   task automatic apply_reset();
      drive(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] exp;
      apply_reset();
      exp = {1'b1, 1'b0, 1'b0, 2'd0};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected %b", status(), exp);
      end
   endtask

   task automatic test_pass();
      logic [4:0] exp;
      apply_reset();
      drive(1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 2'd0};
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         n_checks++;
         if (status() !== exp) begin
            n_fail++;
            $display("FAIL pass_grant_cycle%0d: got %b expected %b", i, status(), exp);
         end
      end
      step();
      exp = {1'b1, 1'b0, 1'b0, 2'd0};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL pass_grant_end: got %b expected %b", status(), exp);
      end
   endtask

   task automatic test_lockout();
      logic [4:0] exp;
      apply_reset();
      drive(1'b1, 1'b0, 1'b1);
      step();
      exp = {1'b1, 1'b0, 1'b0, 2'd1};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL lock_fail1: got %b expected %b", status(), exp);
      end
      step();
      exp = {1'b1, 1'b0, 1'b0, 2'd2};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL lock_fail2: got %b expected %b", status(), exp);
      end
      step();
      // Hold a valid passing verdict for the whole lockout; it must be ignored.
      drive(1'b1, 1'b1, 1'b0);
      exp = {1'b0, 1'b0, 1'b1, 2'd3};
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
         n_checks++;
         if (status() !== exp) begin
            n_fail++;
            $display("FAIL lock_cycle%0d: got %b expected %b", i, status(), exp);
         end
      end
      step();
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 2'd0};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL lock_exit: got %b expected %b", status(), exp);
      end
   endtask

   task automatic test_mixed();
      logic [4:0] exp;
      apply_reset();
      drive(1'b1, 1'b0, 1'b1);
      step();
      step();
      drive(1'b1, 1'b1, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 2'd2};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL mixed_two_fails: got %b expected %b", status(), exp);
      end
      step();
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b1, 1'b0, 2'd0};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL mixed_pass_grant: got %b expected %b", status(), exp);
      end
      for (int i = 0; i < 4; i++) step();
      drive(1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 2'd1};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL mixed_fail_after_pass: got %b expected %b", status(), exp);
      end
   endtask

   task automatic test_inconsistent();
      logic [4:0] exp;
      apply_reset();
      drive(1'b1, 1'b1, 1'b1);
      step();
      exp = {1'b1, 1'b0, 1'b0, 2'd1};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL incons_11: got %b expected %b", status(), exp);
      end
      drive(1'b1, 1'b0, 1'b0);
      step();
      exp = {1'b1, 1'b0, 1'b0, 2'd2};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL incons_00: got %b expected %b", status(), exp);
      end
      drive(1'b1, 1'b1, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b0);
      exp = {1'b0, 1'b0, 1'b1, 2'd3};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL incons_lock: got %b expected %b", status(), exp);
      end
   endtask

   task automatic test_reset_mid_lock();
      logic [4:0] exp;
      apply_reset();
      drive(1'b1, 1'b0, 1'b1);
      step();
      step();
      step();
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      exp = {1'b0, 1'b0, 1'b1, 2'd3};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL midlock_before_rst: got %b expected %b", status(), exp);
      end
`ifdef AUDIT_COUNT_EN
      n_checks++;
      if (total_fails !== 16'd3) begin
         n_fail++;
         $display("FAIL audit_before_rst: got %0d expected 3", total_fails);
      end
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 2'd0};
      n_checks++;
      if (status() !== exp) begin
         n_fail++;
         $display("FAIL midlock_after_rst: got %b expected %b", status(), exp);
      end
`ifdef AUDIT_COUNT_EN
      n_checks++;
      if (total_fails !== 16'd0) begin
         n_fail++;
         $display("FAIL audit_after_rst: got %0d expected 0", total_fails);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      test_reset();
      test_pass();
      test_lockout();
      test_mixed();
      test_inconsistent();
      test_reset_mid_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
